// File: rtl/bus_access_scheduler.sv
// Round-robin bus-tenure scheduler: one owner at a time, whole-burst grants, beat mux to the shared port.
// Optional macro BUS_SCHED_PRIO0_EN: client 0 always wins arbitration and never moves the rr pointer.
//
// state   | meaning
// IDLE    | no owner; arbitrate among req_i, grant on the next edge
// ACTIVE  | owner drives the bus; tenure ends on last beat, beat limit, req drop or stall timeout
// RELEASE | one dead cycle; gnt_o low, owner index and beat count held, rr pointer updated
//
// abort_o / timeout_o are registered and pulse during the RELEASE cycle that the event caused.
module bus_access_scheduler #(
  parameter  int NUM_CLIENTS    = 4,
  parameter  int MAX_BEATS      = 16,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IDX_W          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  localparam int CNT_W          = $clog2(MAX_BEATS + 1),
  localparam int STALL_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [NUM_CLIENTS-1:0] valid_i,
  input  logic [NUM_CLIENTS-1:0] last_i,
  input  logic                   bus_ready_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o,
  output logic                   bus_valid_o,
  output logic                   bus_last_o,
  output logic [CNT_W-1:0]       beat_cnt_o,
  output logic                   abort_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic                   abort_q, abort_d;
  logic                   timeout_q, timeout_d;

  logic                   own_req, own_valid, own_last;
  logic                   active, fire, burst_end, stall_max;
  logic                   hi_found, lo_found, win_found;
  logic [IDX_W-1:0]       hi_idx, lo_idx, win_idx;

  assign own_req   = req_i[gnt_idx_q];
  assign own_valid = valid_i[gnt_idx_q];
  assign own_last  = last_i[gnt_idx_q];
  assign active    = (state_q == ST_ACTIVE);
  assign fire      = active & own_valid & bus_ready_i;
  assign burst_end = own_last | (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign stall_max = (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  // Rotating search: lowest requester above ptr wins, otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        if (j > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(j);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
`ifdef BUS_SCHED_PRIO0_EN
    if (req_i[0]) begin
      win_idx = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    stall_d    = stall_q;
    abort_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_ACTIVE;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          gnt_idx_d        = win_idx;
          beat_cnt_d       = '0;
          stall_d          = '0;
        end
      end

      ST_ACTIVE: begin
        // A beat on the bus outranks both a req drop and the stall limit.
        if (fire && burst_end) begin
          state_d    = ST_RELEASE;
          gnt_d      = '0;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else if (!own_req && !fire) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          abort_d = 1'b1;
        end else if (!fire && stall_max) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else if (fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          stall_d    = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end

      ST_RELEASE: begin
        state_d   = ST_IDLE;
        gnt_idx_d = '0;
`ifdef BUS_SCHED_PRIO0_EN
        if (gnt_idx_q != '0) begin
          ptr_d = gnt_idx_q;
        end
`else
        ptr_d = gnt_idx_q;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= IDX_W'(NUM_CLIENTS - 1);
      beat_cnt_q <= '0;
      stall_q    <= '0;
      abort_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      stall_q    <= stall_d;
      abort_q    <= abort_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign bus_valid_o = active & own_valid;
  assign bus_last_o  = active & burst_end;
  assign beat_cnt_o  = beat_cnt_q;
  assign abort_o     = abort_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_access_scheduler.sv
// Directed + random bench for bus_access_scheduler against a tenure-level reference model.
module tb_bus_access_scheduler;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, valid, last;
  logic         bus_ready;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         bus_valid, bus_last;
  logic [2:0]   beat_cnt;
  logic         abort, timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how many beats and stall cycles so far, and the rr pointer.
  bit m_act   = 1'b0;
  bit m_rel   = 1'b0;
  bit m_abort = 1'b0;
  bit m_tmo   = 1'b0;
  int m_owner = 0;
  int m_beats = 0;
  int m_stall = 0;
  int m_ptr   = N - 1;
  int grants[$];

  bus_access_scheduler #(
    .NUM_CLIENTS   (N),
    .MAX_BEATS     (MB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .valid_i    (valid),
    .last_i     (last),
    .bus_ready_i(bus_ready),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .bus_valid_o(bus_valid),
    .bus_last_o (bus_last),
    .beat_cnt_o (beat_cnt),
    .abort_o    (abort),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
`ifdef BUS_SCHED_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c = (m_ptr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_update();
    bit fire;
    int w;
    if (!rst_n) begin
      m_act = 0; m_rel = 0; m_abort = 0; m_tmo = 0;
      m_ptr = N - 1; m_beats = 0; m_stall = 0; m_owner = 0;
      return;
    end
    if (m_rel) begin
      m_rel = 0; m_abort = 0; m_tmo = 0;
`ifdef BUS_SCHED_PRIO0_EN
      if (m_owner != 0) m_ptr = m_owner;
`else
      m_ptr = m_owner;
`endif
    end else if (m_act) begin
      fire = valid[m_owner] && bus_ready;
      if (fire) begin
        m_beats++;
        m_stall = 0;
        if (last[m_owner] || m_beats == MB) begin
          m_act = 0; m_rel = 1;
        end
      end else if (!req[m_owner]) begin
        m_act = 0; m_rel = 1; m_abort = 1;
      end else if (m_stall == TO - 1) begin
        m_act = 0; m_rel = 1; m_tmo = 1;
      end else begin
        m_stall++;
      end
    end else begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_act = 1; m_beats = 0; m_stall = 0;
        grants.push_back(w);
      end
    end
  endfunction

  task automatic compare();
    chk("gnt", 32'(gnt), m_act ? (32'd1 << m_owner) : 32'd0);
    chk("bus_valid", 32'(bus_valid), 32'(m_act && valid[m_owner]));
    chk("bus_last", 32'(bus_last), 32'(m_act && (last[m_owner] || m_beats == MB - 1)));
    chk("abort", 32'(abort), 32'(m_abort));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    if (m_act || m_rel) begin
      chk("gnt_idx", 32'(gnt_idx), 32'(m_owner));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_beats));
    end
  endtask

  // Inputs are applied at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_inputs();
    req = '0; valid = '0; last = '0;
  endtask

  task automatic chk_grants(input string tag, input int exp_q[$]);
    chk({tag, "_count"}, 32'(grants.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grants.size(); i++)
      chk(tag, 32'(grants[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int exp_rr[$];
    int exp_p[$];
    rst_n = 1'b0; bus_ready = 1'b0;
    clear_inputs();

    // reset
    @(posedge clk); model_update(); @(negedge clk);
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // single client, last on the third beat
    rst_n = 1'b1; bus_ready = 1'b1;
    req = 4'b0001; valid = 4'b0001;
    step();
    chk("s1_gnt_latency", 32'(gnt), 32'b0001);
    run(2);
    last = 4'b0001;
    step();
    chk("s1_beats", 32'(beat_cnt), 32'd3);
    chk("s1_release_gnt", 32'(gnt), 32'd0);
    clear_inputs();
    step();
    chk("s1_dead_gnt", 32'(gnt), 32'd0);
    step();

    // all clients requesting, single-beat bursts
    rst_n = 1'b0; step(); rst_n = 1'b1;
    grants.delete();
    req = 4'b1111; valid = 4'b1111; last = 4'b1111;
    run(15);
`ifdef BUS_SCHED_PRIO0_EN
    exp_rr = '{0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0};
`endif
    chk_grants("rr_order", exp_rr);
    clear_inputs();

    // forced release at the beat limit
    req = 4'b0010; valid = 4'b0010;
    step();
    chk("s3_gnt", 32'(gnt), 32'b0010);
    run(4);
    chk("s3_beats", 32'(beat_cnt), 32'd4);
    chk("s3_release_gnt", 32'(gnt), 32'd0);
    chk("s3_idx", 32'(gnt_idx), 32'd1);
    clear_inputs();
    step();

    // stall timeout with another requester waiting
    req = 4'b1100;
    step();
    chk("s4_gnt", 32'(gnt), 32'b0100);
    run(7);
    chk("s4_no_timeout_yet", 32'(timeout), 32'd0);
    chk("s4_still_granted", 32'(gnt), 32'b0100);
    step();
    chk("s4_timeout", 32'(timeout), 32'd1);
    chk("s4_revoked", 32'(gnt), 32'd0);
    step();
    chk("s4_timeout_pulse", 32'(timeout), 32'd0);
    step();
    chk("s4_next_owner", 32'(gnt), 32'b1000);
    valid = 4'b1000; last = 4'b1000;
    step();
    clear_inputs();
    step();

    // req drop without a beat, then drop coinciding with a beat
    req = 4'b0001; valid = 4'b0001;
    step();
    chk("s5_gnt", 32'(gnt), 32'b0001);
    step();
    req = '0; valid = '0;
    step();
    chk("s5_abort", 32'(abort), 32'd1);
    chk("s5_abort_gnt", 32'(gnt), 32'd0);
    chk("s5_abort_beats", 32'(beat_cnt), 32'd1);
    step();
    chk("s5_abort_pulse", 32'(abort), 32'd0);
    req = 4'b0110;
    step();
    chk("s5_ptr_owner", 32'(gnt), 32'b0010);
    req = 4'b0100; valid = 4'b0010;
    step();
    chk("s5_fire_wins", 32'(abort), 32'd0);
    chk("s5_fire_counted", 32'(beat_cnt), 32'd1);
    chk("s5_fire_gnt", 32'(gnt), 32'b0010);
    valid = '0;
    step();
    chk("s5_late_abort", 32'(abort), 32'd1);
    clear_inputs();
    run(2);

    // client 0 priority versus plain rotation
    rst_n = 1'b0; step(); rst_n = 1'b1;
    grants.delete();
    req = 4'b0001; valid = 4'b0001; last = 4'b0001;
    run(3);
    req = 4'b0111; valid = 4'b0111; last = 4'b0111;
    run(9);
`ifdef BUS_SCHED_PRIO0_EN
    exp_p = '{0, 0, 0, 0};
`else
    exp_p = '{0, 1, 2, 0};
`endif
    chk_grants("prio_order", exp_p);
    clear_inputs();
    run(2);

    // random traffic, occasional reset mid-tenure
    rst_n = 1'b0; step();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      valid     = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      last      = 4'($urandom) & 4'($urandom);
      bus_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
